pipelined_cla_adder: RTL
========================

// Module: pipelined_cla_adder
// PURPOSE
//  Parametrised, two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
//  Generalises the 16-bit single-level block-carry lookahead to any WIDTH that is a multiple of 4.
//  Block generate/propagate terms are registered in stage 1; block carries, sum and flags are resolved in stage 2.
//  Used by the KGP-RISC ALU/address path wherever a 1-result-per-cycle adder with backpressure is needed.
// PARAMETERS
//  WIDTH       32   operand/sum width; must be a multiple of BLK_W, >= 8
//  BLK_W       4    bits per lookahead block (fixed 4; parameter exists for assertion only)
//  NUM_BLK     WIDTH/BLK_W   derived, not overridable
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands/op valid this cycle
//  in_ready   out  1      adder accepts operands this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in, used by ADC/SBB only
//  op         in   2      00 ADD, 01 ADC, 10 SUB, 11 SBB
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result
//  cout       out  1      raw carry out of MSB (SUB: 1 = no borrow)
//  ovf        out  1      signed overflow: carry into MSB XOR carry out of MSB
//  zero       out  1      sum == 0
// BEHAVIOUR
//  - Reset (rst_n=0, async): both stage valids, out_valid, sum, cout, ovf, zero, all pipe regs -> 0.
//    In-flight operations are dropped; none reappear after reset release. in_ready=1 from first cycle after release.
//  - Operand prep: b_eff = op[1] ? ~b : b; c0 = op==ADD ? 0 : op==ADC ? cin : op==SUB ? 1 : cin.
//  - Stage 1 (on accept): register per-bit p=a^b_eff, per-block G/P (4-bit CLA equations), c0, a[MSB], b_eff[MSB].
//  - Stage 2: lcu_n resolves block carries C1..C(NUM_BLK) from block G/P and c0 (full lookahead,
//    C(i+1) = G(i) | P(i)&C(i) expanded, no ripple); within-block carries by 4-bit CLA; sum=p^carries.
//    Register sum, cout=C(NUM_BLK), ovf, zero.
//  - Latency: exactly 2 cycles from accept (in_valid&in_ready) to out_valid with no backpressure.
//    Throughput 1 op/cycle.
//  - Handshake: s2 advances when !out_valid | out_ready; s1 advances when s2 advances | !s1_valid;
//    in_ready = !s1_valid | s1_advance (combinational from out_ready; no combinational path from in_valid).
//  - While out_valid & !out_ready: sum/cout/ovf/zero and out_valid held stable; at most 2 ops buffered, none lost.
//  - in_valid may drop without acceptance; a,b,op,cin need be stable only in the accept cycle.
//  - Simultaneous accept and output handshake in one cycle: both occur; pipe stays full.
//  - Wrap-around: modulo 2^WIDTH; 0xFFFFFFFF+1 -> sum 0, cout 1, zero 1.
//  - op/cin ignored when not accepted. X on inputs with in_valid=0 must not propagate to outputs.
// STRUCTURE
//  - Shared package (alu_pkg): op encodings OP_ADD/OP_ADC/OP_SUB/OP_SBB, BLK_W=4 constant.
//  - Sub-module: lcu_n #(.N(NUM_BLK)) - combinational N-input lookahead carry unit
//    (inputs P[N-1:0], G[N-1:0], c0; outputs C[N:1]); generate-loop of AND/OR terms.
//  - Stage registers and handshake logic live in this module; elaboration-time check WIDTH%4==0.
// TESTING
//  1 Reset mid-stream: 2 ops in flight, pulse rst_n low 1 cycle -> out_valid=0 async, no stale
//    result after release, in_ready=1.
//  2 ADD 0x0000_FFFF+0x0000_0001 -> sum 0x0001_0000, cout 0, ovf 0, zero 0, out_valid 2 cycles after accept.
//  3 ADD 0x7FFF_FFFF+1 -> sum 0x8000_0000, ovf 1, cout 0; ADD 0xFFFF_FFFF+1 -> sum 0, cout 1, zero 1.
//  4 SUB 5-7 -> sum 0xFFFF_FFFE, cout 0; SBB 5-3 cin=0 -> sum 1, cout 1; ADC 1+1 cin=1 -> sum 3.
//  5 Backpressure: stream 4 ops, out_ready=0 for 3 cycles -> in_ready=0 after 2 accepts, output held
//    stable, all 4 results in order once out_ready=1.
//  6 Random ADD/SUB/ADC/SBB at WIDTH=16/32/64 with random in_valid/out_ready -> scoreboard vs. a+b_eff+c0 model.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: adder op encodings, lookahead block width and 4-bit CLA helpers.
package alu_pkg;

  localparam int BLK_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_ADC = 2'b01,
    OP_SUB = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  // Carries into bits 0..3 of a 4-bit block, fully expanded from the block carry-in.
  function automatic logic [3:0] cla4_carries(input logic [3:0] g, input logic [3:0] p,
                                              input logic ci);
    logic [3:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  function automatic logic block_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

endpackage

// File: rtl/lcu_n.sv
// Combinational N-block lookahead carry unit: every block carry is a flat sum of products
// of block generate/propagate terms and c0, so no carry ripples from block to block.
module lcu_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] p,
  input  logic [N-1:0] g,
  input  logic         c0,
  output logic [N:1]   c
);

  for (genvar i = 0; i < N; i++) begin : g_carry
    logic [i:0] terms;
    for (genvar k = 0; k <= i; k++) begin : g_term
      if (k == i) begin : g_own
        assign terms[k] = g[k];
      end else begin : g_prop
        assign terms[k] = g[k] & (&p[i:k+1]);
      end
    end
    assign c[i+1] = (|terms) | (c0 & (&p[i:0]));
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Stage 1 registers bit and block generate/propagate; stage 2 resolves carries, sum and flags.
module pipelined_cla_adder #(
  parameter int WIDTH = 32,
  parameter int BLK_W = alu_pkg::BLK_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  import alu_pkg::*;

  localparam int NUM_BLK = WIDTH / BLK_W;

  if (BLK_W != 4 || (WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("pipelined_cla_adder: WIDTH must be a multiple of 4 and >= 8, BLK_W must be 4");
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // ready never depends on the valid of the same interface, and a stage holds its
  // contents (data and valid) unchanged while it cannot pass them on.
  logic s1_valid;
  logic s2_advance;
  logic accept;

  assign s2_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s2_advance;
  assign accept     = in_valid && in_ready;

  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH-1:0]   bit_g;
  logic [WIDTH-1:0]   bit_p;
  logic [NUM_BLK-1:0] blk_g;
  logic [NUM_BLK-1:0] blk_p;
  logic               c0;

  always_comb begin
    b_eff = op[1] ? ~b : b;
    case (op)
      OP_ADD:  c0 = 1'b0;
      OP_ADC:  c0 = cin;
      OP_SUB:  c0 = 1'b1;
      default: c0 = cin;
    endcase
    bit_g = a & b_eff;
    bit_p = a ^ b_eff;
    blk_g = '0;
    blk_p = '0;
    for (int i = 0; i < NUM_BLK; i++) begin
      blk_g[i] = block_gen(bit_g[i*BLK_W +: BLK_W], bit_p[i*BLK_W +: BLK_W]);
      blk_p[i] = &bit_p[i*BLK_W +: BLK_W];
    end
  end

  logic [WIDTH-1:0]   s1_g;
  logic [WIDTH-1:0]   s1_p;
  logic [NUM_BLK-1:0] s1_bg;
  logic [NUM_BLK-1:0] s1_bp;
  logic               s1_c0;
  logic               s1_a_msb;
  logic               s1_b_msb;

  // Operand data is captured only on accept so idle or undriven inputs never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_g     <= '0;
      s1_p     <= '0;
      s1_bg    <= '0;
      s1_bp    <= '0;
      s1_c0    <= 1'b0;
      s1_a_msb <= 1'b0;
      s1_b_msb <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_g     <= bit_g;
        s1_p     <= bit_p;
        s1_bg    <= blk_g;
        s1_bp    <= blk_p;
        s1_c0    <= c0;
        s1_a_msb <= a[WIDTH-1];
        s1_b_msb <= b_eff[WIDTH-1];
      end
    end
  end

  logic [NUM_BLK:1]   blk_c;
  logic [NUM_BLK:0]   blk_cin;
  logic [WIDTH-1:0]   bit_c;
  logic [WIDTH-1:0]   sum_next;
  logic               ovf_next;

  lcu_n #(.N(NUM_BLK)) u_lcu (
    .p  (s1_bp),
    .g  (s1_bg),
    .c0 (s1_c0),
    .c  (blk_c)
  );

  always_comb begin
    blk_cin = {blk_c, s1_c0};
    bit_c   = '0;
    for (int i = 0; i < NUM_BLK; i++) begin
      bit_c[i*BLK_W +: BLK_W] = cla4_carries(s1_g[i*BLK_W +: BLK_W], s1_p[i*BLK_W +: BLK_W],
                                             blk_cin[i]);
    end
    sum_next = s1_p ^ bit_c;
    // Same-sign operands producing a result of the other sign is a signed overflow.
    ovf_next = (s1_a_msb ~^ s1_b_msb) & (sum_next[WIDTH-1] ^ s1_a_msb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= sum_next;
        cout <= blk_cin[NUM_BLK];
        ovf  <= ovf_next;
        zero <= (sum_next == '0);
      end
    end
  end

endmodule
